dmem_store_buffer: RTL and testbench

//  Posted-write store buffer between the single-cycle core's data port and backing data memory.

---
 rtl/riscv_mem_pkg.sv | 25 ++
 rtl/stbuf_fwd_match.sv | 41 ++++
 rtl/dmem_store_buffer.sv | 173 +++++++++++++++++
 tb/tb_dmem_store_buffer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types for the data-memory store buffer.
//   word_t        : 32-bit data word
//   waddr_t       : word address, STBUF_AW bits wide (default 30)
//   stbuf_state_e : store buffer controller state
//   stbuf_entry_t : one buffered store {valid, addr, data}
package riscv_mem_pkg;

  localparam int unsigned STBUF_AW = 30;

  typedef logic [31:0]          word_t;
  typedef logic [STBUF_AW-1:0]  waddr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } stbuf_state_e;

  typedef struct packed {
    logic   valid;
    waddr_t addr;
    word_t  data;
  } stbuf_entry_t;

endpackage

// File: rtl/stbuf_fwd_match.sv
// Store-to-load forwarding search.
// Walks the buffer from the youngest entry (tail-1) back towards the oldest
// and returns the data of the first valid entry whose word address matches.
//   entries_i : buffer storage
//   tail_i    : next write slot; tail_i-1 is the youngest entry
//   addr_i    : load word address
//   hit_o     : a matching entry exists
//   data_o    : data of the youngest matching entry (0 when no hit)
module stbuf_fwd_match
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  stbuf_entry_t                 entries_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]     tail_i,
  input  waddr_t                       addr_i,
  output logic                         hit_o,
  output word_t                        data_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    found  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // i+1 == DEPTH wraps to tail_i itself, i.e. the oldest slot when full
      idx = tail_i - PW'(i + 1);
      if (!found && entries_i[idx].valid && (entries_i[idx].addr == addr_i)) begin
        found  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
    hit_o = found;
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the core data port and backing memory.
// Stores are queued in a FIFO and drained over a valid/ready write channel;
// loads read memory combinationally with forwarding from buffered stores.
//
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   memwrite/aluout/writedata : core store strobe, byte address, store data
//   readdata               : load data (combinational from aluout)
//   stall                  : store cannot be accepted this cycle
//   flush                  : pulse; drain buffer and refuse stores until empty
//   empty                  : no buffered stores
//   overflow               : sticky, a store was dropped while stalled
//   mem_raddr/mem_rdata    : backing memory read port
//   wr_valid/wr_ready/wr_addr/wr_data : write channel carrying the head entry
//
// Build option: define STBUF_COALESCE_EN to merge a store into the youngest
// entry when the addresses match.
//
// state | meaning
// IDLE  | buffer empty, accepting stores
// DRAIN | entries pending, accepting stores
// FLUSH | draining, all stores refused until empty
module dmem_store_buffer
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [31:0]   aluout,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  output logic          stall,
  input  logic          flush,
  output logic          empty,
  output logic          overflow,
  output logic [AW-1:0] mem_raddr,
  input  logic [31:0]   mem_rdata,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  stbuf_state_e  state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          overflow_q, overflow_d;
  stbuf_entry_t  entries_q [DEPTH];
  stbuf_entry_t  entries_d [DEPTH];

  waddr_t word_addr;
  logic   full;
  logic   pop;
  logic   push;
  logic   coalesce;
  logic   fwd_hit;
  word_t  fwd_data;
  logic   unused_bits;

  assign word_addr   = waddr_t'(aluout[AW+1:2]);
  assign unused_bits = ^aluout[1:0];
  assign full        = (count_q == FULL_CNT);
  assign wr_valid    = (count_q != '0);
  assign empty       = (count_q == '0);
  assign pop         = wr_valid && wr_ready;
  assign overflow    = overflow_q;
  assign wr_addr     = entries_q[head_q].addr[AW-1:0];
  assign wr_data     = entries_q[head_q].data;
  assign mem_raddr   = aluout[AW+1:2];

`ifdef STBUF_COALESCE_EN
  logic [PW-1:0] youngest;
  assign youngest = tail_q - PW'(1);
  // Merge is blocked when the youngest entry is also the head leaving this cycle.
  assign coalesce = memwrite && (state_q != FLUSH) && (count_q != '0)
                    && (entries_q[youngest].addr == word_addr)
                    && !(pop && (youngest == head_q));
`else
  assign coalesce = 1'b0;
`endif

  // Output logic: a full buffer still accepts when the head leaves or the store merges.
  always_comb begin
    stall = (state_q == FLUSH) || (full && !pop && !coalesce);
  end

  assign push = memwrite && !stall && !coalesce;

  always_comb begin
    entries_d = entries_q;
    if (pop) begin
      entries_d[head_q].valid = 1'b0;
    end
`ifdef STBUF_COALESCE_EN
    if (coalesce) begin
      entries_d[youngest].data = writedata;
    end
`endif
    // Applied after pop so a full-buffer push into the freed slot sticks.
    if (push) begin
      entries_d[tail_q] = '{valid: 1'b1, addr: word_addr, data: writedata};
    end
  end

  always_comb begin
    count_d    = count_q + CW'(push) - CW'(pop);
    head_d     = pop  ? head_q + PW'(1) : head_q;
    tail_d     = push ? tail_q + PW'(1) : tail_q;
    overflow_d = overflow_q || (memwrite && stall);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush)     state_d = FLUSH;
        else if (push) state_d = DRAIN;
      end
      DRAIN: begin
        if (flush)              state_d = FLUSH;
        else if (count_d == '0) state_d = IDLE;
      end
      FLUSH: begin
        if (count_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_d;
      entries_q  <= entries_d;
    end
  end

  stbuf_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd (
    .entries_i (entries_q),
    .tail_i    (tail_q),
    .addr_i    (word_addr),
    .hit_o     (fwd_hit),
    .data_o    (fwd_data)
  );

  assign readdata = fwd_hit ? fwd_data : mem_rdata;

endmodule

// File: tb/tb_dmem_store_buffer.sv
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 30;

  logic          clk = 1'b0;
  logic          reset;
  logic          memwrite;
  logic [31:0]   aluout;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          stall;
  logic          flush;
  logic          empty;
  logic          overflow;
  logic [AW-1:0] mem_raddr;
  logic [31:0]   mem_rdata;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  always #5 clk = ~clk;

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata),
    .stall     (stall),
    .flush     (flush),
    .empty     (empty),
    .overflow  (overflow),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        rst, mw, rdy, chk;
    logic [31:0] a, wd, mrd;
    logic        e_stall, e_empty, e_ovf, e_wrv;
    logic [31:0] e_rd, e_haddr, e_hdata;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vt[$];
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic rst, input logic mw, input logic [31:0] a,
                        input logic [31:0] wd, input logic rdy, input logic fl,
                        input logic [31:0] mrd);
    @(negedge clk);
    reset     = rst;
    memwrite  = mw;
    aluout    = a;
    writedata = wd;
    wr_ready  = rdy;
    flush     = fl;
    mem_rdata = mrd;
    #3;
  endtask

  // Compare a write-channel handshake against the oldest expected store.
  task automatic sb_pop();
    wr_t e;
    if (wr_valid && wr_ready && !reset) begin
      pops++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_write: got addr=%h data=%h expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("sb_wr_data", wr_data, e.data);
      end
    end
  endtask

  task automatic end_cycle(input logic push_exp, input logic [31:0] a,
                           input logic [31:0] wd, input logic rst);
    wr_t e;
    if (push_exp) begin
      e.addr = a[31:2];
      e.data = wd;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (rst) exp_q.delete();
  endtask

  function automatic vec_t mk(input logic rst, input logic mw, input logic [31:0] a,
                              input logic [31:0] wd, input logic rdy, input logic [31:0] mrd,
                              input logic c, input logic s, input logic em, input logic ov,
                              input logic wv, input logic [31:0] rd,
                              input logic [31:0] ha, input logic [31:0] hd);
    vec_t v;
    v.rst = rst; v.mw = mw; v.a = a; v.wd = wd; v.rdy = rdy; v.mrd = mrd; v.chk = c;
    v.e_stall = s; v.e_empty = em; v.e_ovf = ov; v.e_wrv = wv;
    v.e_rd = rd; v.e_haddr = ha; v.e_hdata = hd;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int exp_pops;
    int p0;
    reset = 1'b1; memwrite = 1'b0; aluout = '0; writedata = '0;
    wr_ready = 1'b0; flush = 1'b0; mem_rdata = '0;

    //            rst mw  addr    wdata         rdy mrd          chk stl emp ovf wrv rd            haddr   hdata
    vt.push_back(mk(1, 0, 32'h0,   32'h0,        0, 32'h0,        0,  0,  0,  0,  0, 32'h0,        32'h0,  32'h0));
    vt.push_back(mk(0, 0, 32'h100, 32'h0,        0, 32'h0A0A0A0A, 1,  0,  1,  0,  0, 32'h0A0A0A0A, 32'h0,  32'h0));
    vt.push_back(mk(0, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0,        1,  0,  1,  0,  0, 32'h0,        32'h0,  32'h0));
    vt.push_back(mk(0, 0, 32'h100, 32'h0,        0, 32'h0,        1,  0,  0,  0,  1, 32'hDEADBEEF, 32'h40, 32'hDEADBEEF));
    vt.push_back(mk(0, 1, 32'h104, 32'h1,        0, 32'h0,        1,  0,  0,  0,  1, 32'h0,        32'h40, 32'hDEADBEEF));
    vt.push_back(mk(0, 1, 32'h108, 32'h2,        0, 32'h0,        1,  0,  0,  0,  1, 32'h0,        32'h40, 32'hDEADBEEF));
    vt.push_back(mk(0, 1, 32'h10C, 32'h3,        0, 32'h0,        1,  0,  0,  0,  1, 32'h0,        32'h40, 32'hDEADBEEF));
    vt.push_back(mk(0, 1, 32'h110, 32'h4,        0, 32'h0,        1,  1,  0,  0,  1, 32'h0,        32'h40, 32'hDEADBEEF));
    vt.push_back(mk(0, 0, 32'h104, 32'h0,        0, 32'h0,        1,  1,  0,  1,  1, 32'h1,        32'h40, 32'hDEADBEEF));
    vt.push_back(mk(0, 0, 32'h100, 32'h0,        1, 32'h0,        1,  0,  0,  1,  1, 32'hDEADBEEF, 32'h40, 32'hDEADBEEF));
    vt.push_back(mk(0, 0, 32'h100, 32'h0,        1, 32'h55,       1,  0,  0,  1,  1, 32'h55,       32'h41, 32'h1));
    vt.push_back(mk(0, 0, 32'h108, 32'h0,        1, 32'h55,       1,  0,  0,  1,  1, 32'h2,        32'h42, 32'h2));
    vt.push_back(mk(0, 0, 32'h10C, 32'h0,        1, 32'h0,        1,  0,  0,  1,  1, 32'h3,        32'h43, 32'h3));
    vt.push_back(mk(0, 0, 32'h10C, 32'h0,        0, 32'h66,       1,  0,  1,  1,  0, 32'h66,       32'h0,  32'h0));
    vt.push_back(mk(1, 0, 32'h0,   32'h0,        0, 32'h0,        1,  0,  1,  1,  0, 32'h0,        32'h0,  32'h0));
    vt.push_back(mk(0, 1, 32'h300, 32'hA0,       0, 32'h0,        1,  0,  1,  0,  0, 32'h0,        32'h0,  32'h0));
    vt.push_back(mk(0, 1, 32'h304, 32'hA1,       0, 32'h0,        1,  0,  0,  0,  1, 32'h0,        32'hC0, 32'hA0));
    vt.push_back(mk(0, 1, 32'h308, 32'hA2,       0, 32'h0,        1,  0,  0,  0,  1, 32'h0,        32'hC0, 32'hA0));
    vt.push_back(mk(0, 1, 32'h30C, 32'hA3,       0, 32'h0,        1,  0,  0,  0,  1, 32'h0,        32'hC0, 32'hA0));
    vt.push_back(mk(0, 1, 32'h310, 32'hA4,       1, 32'h0,        1,  0,  0,  0,  1, 32'h0,        32'hC0, 32'hA0));
    vt.push_back(mk(0, 0, 32'h310, 32'h0,        0, 32'h0,        1,  1,  0,  0,  1, 32'hA4,       32'hC1, 32'hA1));
    vt.push_back(mk(0, 0, 32'h304, 32'h0,        1, 32'h0,        1,  0,  0,  0,  1, 32'hA1,       32'hC1, 32'hA1));
    vt.push_back(mk(0, 0, 32'h300, 32'h0,        1, 32'h9,        1,  0,  0,  0,  1, 32'h9,        32'hC2, 32'hA2));
    vt.push_back(mk(0, 0, 32'h30C, 32'h0,        1, 32'h0,        1,  0,  0,  0,  1, 32'hA3,       32'hC3, 32'hA3));
    vt.push_back(mk(0, 0, 32'h310, 32'h0,        1, 32'h0,        1,  0,  0,  0,  1, 32'hA4,       32'hC4, 32'hA4));
    vt.push_back(mk(0, 0, 32'h310, 32'h0,        0, 32'h9,        1,  0,  1,  0,  0, 32'h9,        32'h0,  32'h0));
    vt.push_back(mk(0, 1, 32'h400, 32'hB0,       0, 32'h0,        1,  0,  1,  0,  0, 32'h0,        32'h0,  32'h0));
    vt.push_back(mk(0, 1, 32'h404, 32'hB1,       0, 32'h0,        1,  0,  0,  0,  1, 32'h0,        32'h100, 32'hB0));
    vt.push_back(mk(1, 0, 32'h400, 32'h0,        0, 32'h77,       1,  0,  0,  0,  1, 32'hB0,       32'h100, 32'hB0));
    vt.push_back(mk(0, 0, 32'h400, 32'h0,        0, 32'h77,       1,  0,  1,  0,  0, 32'h77,       32'h0,  32'h0));

    foreach (vt[i]) begin
      set_in(vt[i].rst, vt[i].mw, vt[i].a, vt[i].wd, vt[i].rdy, 1'b0, vt[i].mrd);
      sb_pop();
      if (vt[i].chk) begin
        chk($sformatf("v%0d_stall", i),    32'(stall),    32'(vt[i].e_stall));
        chk($sformatf("v%0d_empty", i),    32'(empty),    32'(vt[i].e_empty));
        chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vt[i].e_ovf));
        chk($sformatf("v%0d_wr_valid", i), 32'(wr_valid), 32'(vt[i].e_wrv));
        chk($sformatf("v%0d_readdata", i), readdata,      vt[i].e_rd);
        chk($sformatf("v%0d_mem_raddr", i), 32'(mem_raddr), 32'(vt[i].a[31:2]));
        if (vt[i].e_wrv) begin
          chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr), vt[i].e_haddr);
          chk($sformatf("v%0d_wr_data", i), wr_data,      vt[i].e_hdata);
        end
      end
      end_cycle(vt[i].mw && !vt[i].e_stall && !vt[i].rst, vt[i].a, vt[i].wd, vt[i].rst);
    end
    chk("table_leftover", exp_q.size(), 0);

    // Same-address stores: forwarding returns the youngest, drain order kept.
    set_in(1, 0, 0, 0, 0, 0, 0); end_cycle(0, 0, 0, 1);
    set_in(0, 1, 32'h200, 32'h11, 0, 0, 0); sb_pop(); end_cycle(1, 32'h200, 32'h11, 0);
    set_in(0, 1, 32'h200, 32'h22, 0, 0, 0); sb_pop();
    chk("t4_stall", 32'(stall), 0);
`ifdef STBUF_COALESCE_EN
    exp_q[exp_q.size()-1].data = 32'h22;
    end_cycle(0, 32'h200, 32'h22, 0);
    exp_pops = 1;
`else
    end_cycle(1, 32'h200, 32'h22, 0);
    exp_pops = 2;
`endif
    set_in(0, 0, 32'h200, 0, 0, 0, 32'h0); sb_pop();
    chk("t4_readdata", readdata, 32'h22);
    chk("t4_empty", 32'(empty), 0);
    p0 = pops;
    for (int k = 0; k < 4; k++) begin
      set_in(0, 0, 32'h200, 0, 1, 0, 32'h0); sb_pop(); end_cycle(0, 0, 0, 0);
    end
    set_in(0, 0, 32'h200, 0, 0, 0, 32'h5A); sb_pop();
    chk("t4_pops", pops - p0, exp_pops);
    chk("t4_empty_end", 32'(empty), 1);
    chk("t4_readdata_end", readdata, 32'h5A);
    chk("t4_overflow", 32'(overflow), 0);
    chk("t4_leftover", exp_q.size(), 0);
    end_cycle(0, 0, 0, 0);

    // Flush with three entries: stores refused until drained.
    set_in(1, 0, 0, 0, 0, 0, 0); end_cycle(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1, 32'h500 + 32'(4 * k), 32'hC0 + 32'(k), 0, 0, 0); sb_pop();
      end_cycle(1, 32'h500 + 32'(4 * k), 32'hC0 + 32'(k), 0);
    end
    set_in(0, 0, 32'h500, 0, 0, 1, 0); sb_pop();
    chk("t5_stall_pre", 32'(stall), 0);
    end_cycle(0, 0, 0, 0);
    set_in(0, 1, 32'h600, 32'hEE, 0, 0, 0); sb_pop();
    chk("t5_stall_store", 32'(stall), 1);
    end_cycle(0, 32'h600, 32'hEE, 0);
    set_in(0, 0, 32'h600, 0, 0, 0, 32'h31); sb_pop();
    chk("t5_overflow", 32'(overflow), 1);
    chk("t5_dropped_not_fwd", readdata, 32'h31);
    end_cycle(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 32'h500, 0, 1, 0, 0); sb_pop();
      chk($sformatf("t5_stall_drain%0d", k), 32'(stall), 1);
      chk($sformatf("t5_empty_drain%0d", k), 32'(empty), 0);
      end_cycle(0, 0, 0, 0);
    end
    set_in(0, 0, 32'h500, 0, 0, 0, 0); sb_pop();
    chk("t5_empty_done", 32'(empty), 1);
    chk("t5_stall_done", 32'(stall), 0);
    chk("t5_leftover", exp_q.size(), 0);
    end_cycle(0, 0, 0, 0);

    // Flush on an empty buffer stalls for exactly one cycle.
    set_in(0, 0, 0, 0, 0, 1, 0); sb_pop();
    chk("t5e_stall0", 32'(stall), 0);
    end_cycle(0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0); sb_pop();
    chk("t5e_stall1", 32'(stall), 1);
    end_cycle(0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0); sb_pop();
    chk("t5e_stall2", 32'(stall), 0);
    chk("t5e_wr_valid", 32'(wr_valid), 0);
    end_cycle(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
